// File: rtl/frog_game_sequencer_pkg.sv
// frog_game_sequencer_pkg: shared game constants, state encoding and lane period helper.
package frog_game_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_e;
  localparam int               DEF_NUM_LANES    = 4;
  localparam logic [31:0]      DEF_LANE_PERIODS = {8'd2, 8'd5, 8'd3, 8'd4};
  localparam logic [7:0]       DEF_MIN_PERIOD   = 8'd1;
  localparam logic [1:0]       DEF_START_LIVES  = 2'd3;
  localparam logic [9:0]       DEF_GOAL_Y       = 10'd32;
  localparam logic [7:0]       DEF_HIT_FRAMES   = 8'd60;
  localparam logic [7:0]       DEF_WIN_FRAMES   = 8'd30;
  localparam logic [3:0]       DEF_MAX_LEVEL    = 4'd15;
  // Subtract the level from the base period without going below the floor.
  function automatic logic [7:0] eff_period(input logic [7:0] base, input logic [3:0] lvl,
                                            input logic [7:0] min_p);
    return (base >= {4'd0, lvl} + min_p) ? base - {4'd0, lvl} : min_p;
  endfunction
endpackage

// File: rtl/frog_game_sequencer_lane_scheduler.sv
// lane_scheduler: per-lane frame counter emitting a one-cycle step every period frames.
module lane_scheduler (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [7:0] period,
  output logic       step
);
  logic [7:0] cnt_q;
  logic       due;
  assign due = cnt_q >= period - 8'd1;
  always_ff @(posedge CLK) begin
    if (!RST_N || !enable) begin
      cnt_q <= '0;
      step  <= 1'b0;
    end else begin
      step  <= frame_tick & due;
      cnt_q <= frame_tick ? (due ? '0 : cnt_q + 8'd1) : cnt_q;
    end
  end
endmodule

// File: rtl/frog_game_sequencer.sv
// frog_game_sequencer: game FSM, lives/score/level bookkeeping and lane step scheduling.
module frog_game_sequencer
  import frog_game_sequencer_pkg::*;
#(
  parameter int                           NUM_LANES    = DEF_NUM_LANES,
  parameter logic [8*DEF_NUM_LANES-1:0]   LANE_PERIODS = DEF_LANE_PERIODS,
  parameter logic [7:0]                   MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter logic [1:0]                   START_LIVES  = DEF_START_LIVES,
  parameter logic [9:0]                   GOAL_Y       = DEF_GOAL_Y,
  parameter logic [7:0]                   HIT_FRAMES   = DEF_HIT_FRAMES,
  parameter logic [7:0]                   WIN_FRAMES   = DEF_WIN_FRAMES,
  parameter logic [3:0]                   MAX_LEVEL    = DEF_MAX_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 frame_tick,
  input  logic                 collision,
  input  logic [9:0]           player_y,
  input  logic                 start_btn,
  output logic [2:0]           game_state,
  output logic [NUM_LANES-1:0] lane_step,
  output logic                 player_respawn,
  output logic                 freeze,
  output logic [1:0]           lives,
  output logic [3:0]           level,
  output logic [7:0]           score
);
  state_e     state_q;
  logic [1:0] lives_q;
  logic [3:0] level_q;
  logic [7:0] score_q, frz_q;
  logic       coll_q, start_prev_q, respawn_q, freeze_q;
  logic       start_edge, play, hit, frz_done;
  assign start_edge = start_btn & ~start_prev_q;
  assign play       = state_q == ST_PLAY;
  assign hit        = coll_q | collision;
  assign frz_done   = frz_q == (state_q == ST_HIT ? HIT_FRAMES : WIN_FRAMES) - 8'd1;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] period;
    assign period = eff_period(LANE_PERIODS[8*i +: 8], level_q, MIN_PERIOD);
    lane_scheduler u_lane (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .enable    (play),
      .frame_tick(frame_tick),
      .period    (period),
      .step      (lane_step[i])
    );
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      lives_q      <= START_LIVES;
      level_q      <= '0;
      score_q      <= '0;
      frz_q        <= '0;
      coll_q       <= 1'b0;
      start_prev_q <= 1'b1;
      respawn_q    <= 1'b0;
      freeze_q     <= 1'b1;
    end else begin
      start_prev_q <= start_btn;
      coll_q       <= frame_tick ? 1'b0 : coll_q | (collision & play);
      respawn_q    <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_edge) begin
          state_q   <= ST_PLAY;
          lives_q   <= START_LIVES;
          level_q   <= '0;
          score_q   <= '0;
          respawn_q <= 1'b1;
          freeze_q  <= 1'b0;
        end
        // A collision anywhere in the closing frame beats reaching the goal.
        ST_PLAY: if (frame_tick && (hit || player_y <= GOAL_Y)) begin
          state_q   <= hit ? ST_HIT : ST_WIN;
          lives_q   <= (hit && lives_q != 2'd0) ? lives_q - 2'd1 : lives_q;
          score_q   <= (!hit && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
          level_q   <= (!hit && level_q < MAX_LEVEL) ? level_q + 4'd1 : level_q;
          respawn_q <= 1'b1;
          freeze_q  <= 1'b1;
          frz_q     <= '0;
        end
        ST_HIT, ST_WIN: if (frame_tick) begin
          if (frz_done) begin
            state_q  <= (state_q == ST_HIT && lives_q == 2'd0) ? ST_OVER : ST_PLAY;
            freeze_q <= state_q == ST_HIT && lives_q == 2'd0;
          end else begin
            frz_q <= frz_q + 8'd1;
          end
        end
        ST_OVER: if (start_edge) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign game_state     = state_q;
  assign player_respawn = respawn_q;
  assign freeze         = freeze_q;
  assign lives          = lives_q;
  assign level          = level_q;
  assign score          = score_q;
endmodule
